// File: rtl/wb_primary_split.sv
// rtl/wb_primary_split.sv - Wishbone primary splitting 64-bit core accesses into 32-bit beats
//
// Purpose: accepts one core request at a time and runs it on a 32-bit Wishbone
// bus. A wide (64-bit) access becomes a low beat at req_addr, an idle gap of
// GAP_CYCLES, then a high beat at req_addr | HIGH_OFFSET. Every beat has an ack
// timeout; on timeout the transaction ends with resp_err and any remaining beat
// is skipped.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready           core request handshake (ready only when idle)
//   req_we, req_wide              write / 64-bit qualifiers
//   req_addr, req_wdata           low-word byte address, write data
//   resp_valid, resp_rdata,
//   resp_err                      one-cycle response pulse, read data, timeout flag
//   cyc, stb, we, addr, dat_o     Wishbone request outputs
//   dat_i, ack                    Wishbone response inputs
//
// Optional feature macro: WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
//   Wide reads run HI, LO, HI and repeat LO, HI until two consecutive high
//   words match, giving tear-free reads of a counter that carries between beats.

`timescale 1ns/1ps

module wb_primary_split #(
    parameter int ADDR_SIZE      = 32,
    parameter int HIGH_OFFSET    = 64,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_wide,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [63:0]          req_wdata,
    output logic                 resp_valid,
    output logic [63:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 cyc,
    output logic                 stb,
    output logic                 we,
    output logic [ADDR_SIZE-1:0] addr,
    output logic [31:0]          dat_o,
    input  logic [31:0]          dat_i,
    input  logic                 ack
);

    localparam int                   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]           GAP_LAST = 3'(GAP_CYCLES - 1);
    localparam logic [ADDR_SIZE-1:0] HI_OFS   = ADDR_SIZE'(HIGH_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BEAT_LO = 3'd1,
        S_GAP     = 3'd2,
        S_BEAT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic                   wide_q, wide_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [63:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [2:0]             gap_q, gap_d;
    // Selects which beat follows the gap; only a consistent read ever goes back to LO.
    logic                   gap_to_lo_q, gap_to_lo_d;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
    logic [31:0]            hi_prev_q, hi_prev_d;
    logic                   have_hi_q, have_hi_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            gap_q       <= '0;
            gap_to_lo_q <= 1'b0;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
            hi_prev_q   <= '0;
            have_hi_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wide_q      <= wide_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            gap_to_lo_q <= gap_to_lo_d;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
            hi_prev_q   <= hi_prev_d;
            have_hi_q   <= have_hi_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wide_d      = wide_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        gap_to_lo_d = gap_to_lo_q;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
        hi_prev_d   = hi_prev_q;
        have_hi_d   = have_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    wide_d  = req_wide;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
                    tmo_d   = '0;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
                    have_hi_d = 1'b0;
                    if (req_wide && !req_we) state_d = S_BEAT_HI;
                    else                     state_d = S_BEAT_LO;
`else
                    state_d = S_BEAT_LO;
`endif
                end
            end
            S_BEAT_LO: begin
                if (ack) begin
                    if (!we_q) begin
                        // A narrow read clears the upper half; a wide read fills it later.
                        if (wide_q) rdata_d[31:0] = dat_i;
                        else        rdata_d       = {32'h0, dat_i};
                    end
                    if (wide_q) begin
                        state_d     = S_GAP;
                        gap_d       = '0;
                        gap_to_lo_d = 1'b0;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = gap_to_lo_q ? S_BEAT_LO : S_BEAT_HI;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            S_BEAT_HI: begin
                if (ack) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d[63:32] = dat_i;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
                        // Finish only once two successive high words agree.
                        if (!have_hi_q || (dat_i != hi_prev_q)) begin
                            hi_prev_d   = dat_i;
                            have_hi_d   = 1'b1;
                            state_d     = S_GAP;
                            gap_d       = '0;
                            gap_to_lo_d = 1'b1;
                        end
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = (state_q == S_RESP) && err_q;
        resp_rdata = rdata_q;
        cyc        = 1'b0;
        stb        = 1'b0;
        we         = 1'b0;
        addr       = '0;
        dat_o      = '0;
        case (state_q)
            S_BEAT_LO: begin
                cyc   = 1'b1;
                stb   = 1'b1;
                we    = we_q;
                addr  = addr_q;
                dat_o = wdata_q[31:0];
            end
            S_BEAT_HI: begin
                cyc   = 1'b1;
                stb   = 1'b1;
                we    = we_q;
                addr  = addr_q | HI_OFS;
                dat_o = wdata_q[63:32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_primary_split.sv
// tb/tb_wb_primary_split.sv - directed vector bench for wb_primary_split

`timescale 1ns/1ps

module tb_wb_primary_split;

    localparam int G   = 2;
    localparam int TMO = 8;
`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
    localparam int WR_LAT   = 8 + 2 * G;
    localparam int WR_BEATS = 3;
`else
    localparam int WR_LAT   = 6 + G;
    localparam int WR_BEATS = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_wide = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        cyc, stb, we, ack = 1'b0;
    logic [31:0] addr, dat_o, dat_i = '0;

    wb_primary_split #(
        .ADDR_SIZE(32), .HIGH_OFFSET(64), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cyc(cyc), .stb(stb), .we(we), .addr(addr), .dat_o(dat_o),
        .dat_i(dat_i), .ack(ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic        wide;
        logic [31:0] a;
        logic [63:0] wd;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ack_en;
        logic        spur;
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
    } beat_t;

    beat_t       blog[$];
    logic        stb_tr[$];
    logic [31:0] hi_seq[$];
    logic [31:0] lo_seq[$];
    logic [31:0] cur_addr = '0, cur_lo = '0, cur_hi = '0;
    logic        ack_en = 1'b1, spur_en = 1'b0, trace_en = 1'b0, prev_stb = 1'b0;
    int          beat_cyc = 0, resp_cnt = 0, hi_stb = 0, stb_cyc = 0;
    int          n_vec = 0, n_fail = 0;
    vec_t        vt[10];

    // Responder and bus monitor: one process so ack decisions and logging agree.
    always @(negedge clock) begin
        if (!reset) begin
            beat_cyc = 0;
            ack      = 1'b0;
            dat_i    = '0;
            prev_stb = 1'b0;
        end else begin
            if (stb) beat_cyc++;
            else     beat_cyc = 0;
            ack   = 1'b0;
            dat_i = '0;
            if (stb && ack_en && beat_cyc == 2) begin
                ack = 1'b1;
                if (addr == cur_addr) dat_i = (lo_seq.size() > 0) ? lo_seq.pop_front() : cur_lo;
                else                  dat_i = (hi_seq.size() > 0) ? hi_seq.pop_front() : cur_hi;
                blog.push_back('{addr, dat_o, we});
            end else if (!stb && prev_stb && spur_en) begin
                ack   = 1'b1;
                dat_i = 32'hBAD0BAD0;
            end
            if (trace_en) begin
                stb_tr.push_back(stb);
                if (resp_valid) resp_cnt++;
                if (stb) stb_cyc++;
                if (stb && addr == (cur_addr | 32'h40)) hi_stb++;
            end
            prev_stb = stb;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int gap_len();
        int ph = 0;
        int n  = 0;
        foreach (stb_tr[i]) begin
            if (ph == 0 && stb_tr[i]) ph = 1;
            else if (ph == 1 && !stb_tr[i]) begin ph = 2; n = 1; end
            else if (ph == 2) begin
                if (stb_tr[i]) return n;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          got;
        @(negedge clock);
        cur_addr = v.a; cur_lo = v.lo; cur_hi = v.hi;
        ack_en = v.ack_en; spur_en = v.spur;
        blog.delete(); stb_tr.delete();
        resp_cnt = 0; hi_stb = 0; stb_cyc = 0; trace_en = 1'b1;
        req_we = v.we; req_wide = v.wide; req_addr = v.a; req_wdata = v.wd;
        req_valid = 1'b1;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 1; got = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s.resp: no resp_valid within 100 cycles", tag);
        end else begin
            chk({tag, ".rdata"}, rd, v.exp_rd);
            chk({tag, ".err"}, 64'(er), 64'(v.exp_err));
            chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
        end
        repeat (3) @(negedge clock);
        trace_en = 1'b0;
        chk({tag, ".resp_count"}, 64'(resp_cnt), 64'd1);
        chk({tag, ".beats"}, 64'(blog.size()), 64'(v.exp_beats));
        if (!v.ack_en) begin
            chk({tag, ".stb_cycles"}, 64'(stb_cyc), 64'(TMO));
            chk({tag, ".hi_beat"}, 64'(hi_stb), 64'd0);
        end
        if (v.we && v.wide && v.ack_en && blog.size() == 2) begin
            chk({tag, ".b0_addr"}, 64'(blog[0].a), 64'(v.a));
            chk({tag, ".b0_dat"}, 64'(blog[0].d), 64'(v.wd[31:0]));
            chk({tag, ".b0_we"}, 64'(blog[0].w), 64'd1);
            chk({tag, ".b1_addr"}, 64'(blog[1].a), 64'(v.a | 32'h40));
            chk({tag, ".b1_dat"}, 64'(blog[1].d), 64'(v.wd[63:32]));
            chk({tag, ".gap"}, 64'(gap_len()), 64'(G));
        end
        ack_en = 1'b1; spur_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        bit   found;

        //          we    wide  addr        wdata                  lo            hi            ack   spur  exp_rdata              err  lat      beats
        vt[0] = '{1'b0, 1'b0, 32'h10,  64'h0,                 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 64'h00000000_DEADBEEF, 1'b0, 4,       1};
        vt[1] = '{1'b1, 1'b1, 32'h20,  64'h11223344_55667788, 32'h0,        32'h0,        1'b1, 1'b0, 64'h00000000_DEADBEEF, 1'b0, 6 + G,   2};
        vt[2] = '{1'b0, 1'b1, 32'h30,  64'h0,                 32'hCAFEF00D, 32'h12345678, 1'b1, 1'b0, 64'h12345678_CAFEF00D, 1'b0, WR_LAT,  WR_BEATS};
        vt[3] = '{1'b1, 1'b0, 32'h84,  64'h0_A5A5A5A5,        32'h0,        32'h0,        1'b1, 1'b0, 64'h12345678_CAFEF00D, 1'b0, 4,       1};
        vt[4] = '{1'b0, 1'b0, 32'h88,  64'h0,                 32'h0BADF00D, 32'h0,        1'b1, 1'b0, 64'h00000000_0BADF00D, 1'b0, 4,       1};
        vt[5] = '{1'b1, 1'b1, 32'h100, 64'hFEDCBA98_76543210, 32'h0,        32'h0,        1'b1, 1'b1, 64'h00000000_0BADF00D, 1'b0, 6 + G,   2};
        vt[6] = '{1'b0, 1'b0, 32'h10,  64'h0,                 32'h11111111, 32'h0,        1'b0, 1'b0, 64'h00000000_0BADF00D, 1'b1, TMO + 2, 0};
        vt[7] = '{1'b1, 1'b1, 32'h20,  64'h01020304_05060708, 32'h0,        32'h0,        1'b0, 1'b0, 64'h00000000_0BADF00D, 1'b1, TMO + 2, 0};
        vt[8] = '{1'b0, 1'b0, 32'h10,  64'h0,                 32'h13579BDF, 32'h0,        1'b1, 1'b0, 64'h00000000_13579BDF, 1'b0, 4,       1};
        vt[9] = '{1'b0, 1'b1, 32'h30,  64'h0,                 32'h01020304, 32'h0A0B0C0D, 1'b1, 1'b1, 64'h0A0B0C0D_01020304, 1'b0, WR_LAT,  WR_BEATS};

        // Reset state while reset is held low.
        #2;
        chk("rst.cyc", 64'(cyc), 64'd0);
        chk("rst.stb", 64'(stb), 64'd0);
        chk("rst.we", 64'(we), 64'd0);
        chk("rst.addr", 64'(addr), 64'd0);
        chk("rst.dat_o", 64'(dat_o), 64'd0);
        chk("rst.resp_valid", 64'(resp_valid), 64'd0);
        chk("rst.resp_err", 64'(resp_err), 64'd0);
        chk("rst.resp_rdata", resp_rdata, 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Reset asserted during the high beat of a wide write.
        @(negedge clock);
        cur_addr = 32'h200; ack_en = 1'b1; spur_en = 1'b0;
        resp_cnt = 0; trace_en = 1'b1;
        req_we = 1'b1; req_wide = 1'b1; req_addr = 32'h200; req_wdata = 64'hAAAA5555_CCCC3333;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (stb && addr == 32'h240) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL midrst.reach_hi: high beat not seen within 50 cycles");
        end
        #2 reset = 1'b0;
        #1;
        chk("midrst.cyc", 64'(cyc), 64'd0);
        chk("midrst.stb", 64'(stb), 64'd0);
        chk("midrst.resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst.req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clock);
        trace_en = 1'b0;
        chk("midrst.resp_count", 64'(resp_cnt), 64'd0);
        rv = '{1'b0, 1'b0, 32'h10, 64'h0, 32'h600DCAFE, 32'h0, 1'b1, 1'b0, 64'h00000000_600DCAFE, 1'b0, 4, 1};
        run_vec(rv, "postrst");

`ifdef WB_PRIMARY_SPLIT_CONSISTENT_READ_EN
        // Counter at 0x00000000_FFFFFFFF carries between the first HI and LO beats.
        hi_seq = '{32'h0, 32'h1, 32'h1};
        lo_seq = '{32'h5, 32'h7};
        rv = '{1'b0, 1'b1, 32'h300, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h00000001_00000007, 1'b0, 12 + 4 * G, 5};
        run_vec(rv, "consist");
        chk("consist.seq_left", 64'(hi_seq.size() + lo_seq.size()), 64'd0);
        hi_seq.delete();
        lo_seq.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
